// File: rtl/sine_lookup_pkg.sv
// siggen_pkg: shared types and constants for the sine lookup stage.
//   quadrant_t   : phase quadrant (top two phase bits)
//   atten_t      : 2-bit attenuation shift amount
//   MID          : offset-binary midscale at the default sample width
//   ROM_DEPTH    : quarter-wave table depth at the default phase width
//   QSINE_TABLE  : built-in quarter-wave table for the default widths,
//                  entry k = round(127 * sin((k + 0.5) * pi / 128))
package siggen_pkg;

  localparam int A_WIDTH_DEF = 8;
  localparam int D_WIDTH_DEF = 8;
  localparam int MID         = 2 ** (D_WIDTH_DEF - 1);
  localparam int ROM_DEPTH   = 2 ** (A_WIDTH_DEF - 2);

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  typedef logic [1:0] atten_t;

  // The half-step sampling point makes entry k and entry ~k mirror images
  // around 90 degrees, so the falling quadrants just invert the index.
  localparam int QSINE_TABLE [64] = '{
      2,   5,   8,  11,  14,  17,  20,  23,
     26,  29,  32,  35,  38,  41,  44,  47,
     50,  53,  56,  58,  61,  64,  67,  69,
     72,  74,  77,  79,  82,  84,  86,  89,
     91,  93,  95,  97,  99, 101, 103, 105,
    106, 108, 110, 111, 113, 114, 115, 117,
    118, 119, 120, 121, 122, 123, 124, 124,
    125, 125, 126, 126, 127, 127, 127, 127
  };

  function automatic logic quad_mirrored(input quadrant_t q);
    return (q == Q1) || (q == Q3);
  endfunction

  function automatic logic quad_negative(input quadrant_t q);
    return (q == Q2) || (q == Q3);
  endfunction

endpackage

// File: rtl/sine_lookup_if.sv
// sine_lookup_if: phase-in / sample-out bundle of the sine lookup stage.
//   en, phase, offset, amp : from the phase counter side (master drives)
//   dout1, dout2, dvalid   : reconstructed samples (slave drives)
interface sine_lookup_if import siggen_pkg::*; #(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
);

  logic               en;
  logic [A_WIDTH-1:0] phase;
  logic [A_WIDTH-1:0] offset;
  atten_t             amp;
  logic [D_WIDTH-1:0] dout1;
  logic [D_WIDTH-1:0] dout2;
  logic               dvalid;

  modport master (
    output en, phase, offset, amp,
    input  dout1, dout2, dvalid
  );

  modport slave (
    input  en, phase, offset, amp,
    output dout1, dout2, dvalid
  );

endinterface

// File: rtl/sine_lookup_quarter_rom.sv
// quarter_rom: dual-read-port synchronous quarter-wave ROM.
//   clk                : clock
//   i_addr_a, i_addr_b : read addresses, sampled on the rising edge
//   o_data_a, o_data_b : registered table entries, one cycle after address
// Contents come from the built-in table in the package (valid for 6-bit
// address, 7-bit data only).
module quarter_rom import siggen_pkg::*; #(
  parameter int    ADDR_W   = A_WIDTH_DEF - 2,
  parameter int    DATA_W   = D_WIDTH_DEF - 1,
  parameter string ROM_FILE = "quarter_sine.mem"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [ADDR_W-1:0] i_addr_b,
  output logic [DATA_W-1:0] o_data_a,
  output logic [DATA_W-1:0] o_data_b
);

  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;

  always_ff @(posedge clk) begin
    r_data_a <= DATA_W'(QSINE_TABLE[i_addr_a]);
    r_data_b <= DATA_W'(QSINE_TABLE[i_addr_b]);
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;

endmodule

// File: rtl/sine_lookup.sv
// sine_lookup: phase-to-sample stage of the signal generator.
// Rebuilds a full sine cycle from a quarter-wave table for two channels:
// channel 1 at the input phase, channel 2 at phase + offset (mod 2^A).
// Fixed 3-cycle latency, one sample per cycle, never stalls.
//   clk : clock
//   rst : synchronous active-high reset (pipeline control and outputs only)
//   bus : sine_lookup_if slave port
//         en/phase/offset/amp in, dout1/dout2/dvalid out
// Pipeline:
//   S1 : decode quadrants, register table addresses, signs, amp, valid
//   S2 : table read (registered inside quarter_rom), sign/amp/valid carried
//   S3 : attenuate, fold around midscale, register outputs
module sine_lookup import siggen_pkg::*; #(
  parameter int    A_WIDTH  = A_WIDTH_DEF,
  parameter int    D_WIDTH  = D_WIDTH_DEF,
  parameter string ROM_FILE = "quarter_sine.mem"
) (
  input  logic          clk,
  input  logic          rst,
  sine_lookup_if.slave  bus
);

  localparam int IDX_W = A_WIDTH - 2;
  localparam int MAG_W = D_WIDTH - 1;
  localparam logic [D_WIDTH-1:0] MID_CODE = {1'b1, {MAG_W{1'b0}}};

  // ---------------------------------------------------------------- decode
  logic [A_WIDTH-1:0] w_phase2;
  quadrant_t          w_quad1;
  quadrant_t          w_quad2;
  logic [IDX_W-1:0]   w_idx1;
  logic [IDX_W-1:0]   w_idx2;
  logic [IDX_W-1:0]   w_addr1;
  logic [IDX_W-1:0]   w_addr2;

  // Truncating add: channel 2 wraps around the cycle on purpose.
  assign w_phase2 = bus.phase + bus.offset;

  assign w_quad1 = quadrant_t'(bus.phase[A_WIDTH-1 -: 2]);
  assign w_quad2 = quadrant_t'(w_phase2[A_WIDTH-1 -: 2]);
  assign w_idx1  = bus.phase[IDX_W-1:0];
  assign w_idx2  = w_phase2[IDX_W-1:0];

  assign w_addr1 = quad_mirrored(w_quad1) ? ~w_idx1 : w_idx1;
  assign w_addr2 = quad_mirrored(w_quad2) ? ~w_idx2 : w_idx2;

  // -------------------------------------------------------------- stage S1
  logic             r_s1_valid;
  logic [IDX_W-1:0] r_s1_addr1;
  logic [IDX_W-1:0] r_s1_addr2;
  logic             r_s1_neg1;
  logic             r_s1_neg2;
  atten_t           r_s1_amp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= bus.en;
    end
  end

  // Data side is not reset; it is only looked at when the valid bit says so.
  always_ff @(posedge clk) begin
    if (bus.en) begin
      r_s1_addr1 <= w_addr1;
      r_s1_addr2 <= w_addr2;
      r_s1_neg1  <= quad_negative(w_quad1);
      r_s1_neg2  <= quad_negative(w_quad2);
      r_s1_amp   <= bus.amp;
    end
  end

  // -------------------------------------------------------------- stage S2
  logic [MAG_W-1:0] w_rom1;
  logic [MAG_W-1:0] w_rom2;
  logic             r_s2_valid;
  logic             r_s2_neg1;
  logic             r_s2_neg2;
  atten_t           r_s2_amp;

  quarter_rom #(
    .ADDR_W   (IDX_W),
    .DATA_W   (MAG_W),
    .ROM_FILE (ROM_FILE)
  ) u_rom (
    .clk      (clk),
    .i_addr_a (r_s1_addr1),
    .i_addr_b (r_s1_addr2),
    .o_data_a (w_rom1),
    .o_data_b (w_rom2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (r_s1_valid) begin
      r_s2_neg1 <= r_s1_neg1;
      r_s2_neg2 <= r_s1_neg2;
      r_s2_amp  <= r_s1_amp;
    end
  end

  // -------------------------------------------------------------- stage S3
  logic [MAG_W-1:0]   w_mag1;
  logic [MAG_W-1:0]   w_mag2;
  logic [D_WIDTH-1:0] w_samp1;
  logic [D_WIDTH-1:0] w_samp2;
  logic [D_WIDTH-1:0] r_dout1;
  logic [D_WIDTH-1:0] r_dout2;
  logic               r_dvalid;

  assign w_mag1 = w_rom1 >> r_s2_amp;
  assign w_mag2 = w_rom2 >> r_s2_amp;

  // Magnitude never exceeds MID-1, so neither direction can wrap.
  assign w_samp1 = r_s2_neg1 ? (MID_CODE - {1'b0, w_mag1})
                             : (MID_CODE + {1'b0, w_mag1});
  assign w_samp2 = r_s2_neg2 ? (MID_CODE - {1'b0, w_mag2})
                             : (MID_CODE + {1'b0, w_mag2});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout1  <= MID_CODE;
      r_dout2  <= MID_CODE;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= r_s2_valid;
      if (r_s2_valid) begin
        r_dout1 <= w_samp1;
        r_dout2 <= w_samp2;
      end
    end
  end

  assign bus.dout1  = r_dout1;
  assign bus.dout2  = r_dout2;
  assign bus.dvalid = r_dvalid;

endmodule

// File: tb/tb_sine_lookup.sv
// Directed bench for sine_lookup. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_sine_lookup;
  import siggen_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sine_lookup_if #(.A_WIDTH(8), .D_WIDTH(8)) bus_if ();

  sine_lookup #(
    .A_WIDTH  (8),
    .D_WIDTH  (8),
    .ROM_FILE ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_vec = 0;
  int n_bad = 0;
  int tbl [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] p, input logic [7:0] o, input logic [1:0] a);
    bus_if.en     = 1'b1;
    bus_if.phase  = p;
    bus_if.offset = o;
    bus_if.amp    = a;
    step();
  endtask

  task automatic idle();
    bus_if.en = 1'b0;
    step();
  endtask

  function automatic int gold(input int p, input int a);
    int q;
    int k;
    int m;
    q = (p >> 6) & 3;
    k = p & 63;
    if (q == 1 || q == 3) k = 63 - k;
    m = tbl[k] >> a;
    return (q >= 2) ? (128 - m) : (128 + m);
  endfunction

  initial begin
    for (int k = 0; k < 64; k++)
      tbl[k] = $rtoi($floor(127.0 * $sin((k + 0.5) * 3.14159265358979 / 128.0) + 0.5));

    rst           = 1'b1;
    bus_if.en     = 1'b0;
    bus_if.phase  = '0;
    bus_if.offset = '0;
    bus_if.amp    = '0;
    step();
    step();
    chk("reset_dout1", bus_if.dout1, 128);
    chk("reset_dout2", bus_if.dout2, 128);
    chk("reset_dvalid", bus_if.dvalid, 0);
    rst = 1'b0;

    // first sample and latency
    push(8'd0, 8'd0, 2'd0);
    idle();
    chk("lat_early_dvalid", bus_if.dvalid, 0);
    idle();
    chk("lat_dvalid", bus_if.dvalid, 1);
    chk("p0_dout1", bus_if.dout1, 130);
    chk("p0_dout2", bus_if.dout2, 130);
    idle();
    chk("after_dvalid", bus_if.dvalid, 0);
    chk("after_hold", bus_if.dout1, 130);

    // quadrant peaks back to back
    push(8'd64, 8'd0, 2'd0);
    push(8'd128, 8'd0, 2'd0);
    push(8'd192, 8'd0, 2'd0);
    bus_if.en = 1'b0;
    chk("p64_dvalid", bus_if.dvalid, 1);
    chk("p64_dout1", bus_if.dout1, 255);
    step();
    chk("p128_dvalid", bus_if.dvalid, 1);
    chk("p128_dout1", bus_if.dout1, 126);
    step();
    chk("p192_dvalid", bus_if.dvalid, 1);
    chk("p192_dout1", bus_if.dout1, 1);
    step();
    chk("drain_dvalid", bus_if.dvalid, 0);

    // channel-2 offset and wrap-around (200+100 -> 44)
    push(8'd0, 8'd64, 2'd0);
    push(8'd200, 8'd100, 2'd0);
    idle();
    chk("off64_dout1", bus_if.dout1, 130);
    chk("off64_dout2", bus_if.dout2, 255);
    idle();
    chk("wrap_dout1", bus_if.dout1, 4);
    chk("wrap_dout2", bus_if.dout2, 241);

    // attenuation on the positive peak
    push(8'd64, 8'd0, 2'd1);
    push(8'd64, 8'd0, 2'd2);
    push(8'd64, 8'd0, 2'd3);
    bus_if.en = 1'b0;
    chk("amp1_dout1", bus_if.dout1, 191);
    chk("amp1_dout2", bus_if.dout2, 191);
    step();
    chk("amp2_dout1", bus_if.dout1, 159);
    chk("amp2_dout2", bus_if.dout2, 159);
    step();
    chk("amp3_dout1", bus_if.dout1, 143);
    chk("amp3_dout2", bus_if.dout2, 143);

    // en pattern 1,0,1
    push(8'd128, 8'd0, 2'd0);
    idle();
    push(8'd192, 8'd0, 2'd0);
    bus_if.en = 1'b0;
    chk("bub_a_dvalid", bus_if.dvalid, 1);
    chk("bub_a_dout1", bus_if.dout1, 126);
    step();
    chk("bub_gap_dvalid", bus_if.dvalid, 0);
    chk("bub_gap_dout1", bus_if.dout1, 126);
    chk("bub_gap_dout2", bus_if.dout2, 126);
    step();
    chk("bub_b_dvalid", bus_if.dvalid, 1);
    chk("bub_b_dout1", bus_if.dout1, 1);

    // reset with samples in flight, en held high through the reset edge
    push(8'd32, 8'd0, 2'd0);
    push(8'd96, 8'd0, 2'd0);
    rst           = 1'b1;
    bus_if.en     = 1'b1;
    bus_if.phase  = 8'd160;
    step();
    chk("rst_dvalid", bus_if.dvalid, 0);
    chk("rst_dout1", bus_if.dout1, 128);
    chk("rst_dout2", bus_if.dout2, 128);
    rst       = 1'b0;
    bus_if.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_drop_dvalid", bus_if.dvalid, 0);
      chk("rst_drop_dout1", bus_if.dout1, 128);
    end

    // full phase sweep, offset 77, amp cycling with the low phase bits
    for (int j = 0; j < 258; j++) begin
      if (j < 256) begin
        bus_if.en     = 1'b1;
        bus_if.phase  = 8'(j);
        bus_if.offset = 8'd77;
        bus_if.amp    = 2'(j);
      end else begin
        bus_if.en = 1'b0;
      end
      step();
      if (j >= 2) begin
        chk("sweep_dvalid", bus_if.dvalid, 1);
        chk("sweep_dout1", bus_if.dout1, gold(j - 2, (j - 2) % 4));
        chk("sweep_dout2", bus_if.dout2, gold((j - 2 + 77) % 256, (j - 2) % 4));
      end
    end
    step();
    chk("sweep_end_dvalid", bus_if.dvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sine_lookup.md
# sine_lookup

Phase-to-sample stage of the signal generator. It consumes the phase word produced by the upstream phase counter and reconstructs a full sine cycle from a quarter-wave ROM. It drives two output channels: a reference channel and a second channel shifted by a programmable phase offset, each with selectable attenuation. It is a fixed-latency, non-stalling 3-stage pipeline that feeds the DAC/display side of the design.

## Interface
- A_WIDTH, 8, phase word width; ROM depth is 2^(A_WIDTH-2) entries.
- D_WIDTH, 8, output sample width, offset-binary.
- ROM_FILE, "quarter_sine.mem", hex init file for the quarter-wave table.

- clk  in  1  clock; synchronous reset, single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  input phase is valid this cycle.
- phase  in  A_WIDTH  channel-1 phase word, from the phase counter output.
- offset  in  A_WIDTH  channel-2 phase offset, added modulo 2^A_WIDTH.
- amp  in  2  attenuation: magnitude >> amp, applied to both channels.
- dout1  out  D_WIDTH  channel-1 sample.
- dout2  out  D_WIDTH  channel-2 sample.
- dvalid  out  1  dout1/dout2 updated this cycle.

## Operation
- Phase split: quadrant q = p[A-1:A-2], index i = p[A-3:0].
  - Table address: i for q=0,2; ~i (bitwise mirror) for q=1,3.
  - Sign: positive for q=0,1; negative for q=2,3.
- Table entry k = round((2^(D-1)-1) * sin((k+0.5)*pi / 2^(A-1))).
  - The half-step offset makes the ~i mirror exact; no extra entry is needed.
  - Entries are unsigned, D_WIDTH-1 bits.
- Attenuation: mag' = mag >> amp. This is a logical shift, truncating.
- Output: mid + mag' when positive, mid - mag' when negative, with mid = 2^(D-1).
  - The result range is 1..2^D-1 by construction; no saturation logic is needed.
- Channel 2 phase: p2 = phase + offset, truncated to A_WIDTH bits (wrap-around is intended).
- phase, offset and amp are all sampled in the same cycle as en, and travel with that sample through the pipeline. A change to offset or amp therefore affects only samples entered on or after the change.
- en=0 cycles insert bubbles. Bubble stages still clock, but dout1/dout2 hold their last value and dvalid=0.
- The pipeline never stalls; there is no backpressure input.

## Timing
- Stage S1: register phase and p2, the decoded table addresses, sign bits, amp, and valid.
- Stage S2: synchronous ROM read for both channels; sign, amp and valid are carried alongside.
- Stage S3: shift, add/subtract, and register the outputs.
- Latency: en asserted at cycle n gives dvalid=1 at cycle n+3, with the corresponding samples on dout1/dout2.
- Throughput: one sample per cycle. Back-to-back en produces back-to-back dvalid.
- Reset values: dout1 = dout2 = 2^(D-1) (128 at defaults); dvalid = 0; all valid pipe bits = 0.
- Reset mid-operation: all in-flight samples are dropped. Outputs read midscale the cycle after rst is sampled high. The first new dvalid appears 3 cycles after the first en following reset release.
- en held high during reset is ignored.
- ROM contents are not reset; only the pipeline control and output registers are.

## Structure
- Package siggen_pkg holds:
  - the quadrant enum (Q0..Q3);
  - helper constants MID = 2^(D_WIDTH-1) and ROM_DEPTH = 2^(A_WIDTH-2);
  - the attenuation type (2-bit).
- Sub-module quarter_rom: dual-read-port synchronous ROM, initialised with $readmemh(ROM_FILE). Instantiated once with two read ports, or twice with one port each; either is acceptable.
- The top level holds the decode, the pipeline registers and the reconstruction arithmetic.

## Test plan
- Reset, then en=1, phase=0, offset=0, amp=0 → dvalid rises 3 cycles later; dout1 = dout2 = 130.
- Apply phases 64, 128, 192 back-to-back → dout1 = 255, 126, 1 on consecutive dvalid cycles.
- phase=0, offset=64 → dout1 = 130, dout2 = 255. Then phase=200, offset=100 → p2 = 44 (wraps), dout2 = 128 + table[44].
- phase=64 with amp = 1, 2, 3 → dout1 = 191, 159, 143.
- en pattern 1,0,1 → dvalid pattern 1,0,1 three cycles later; dout1 holds its value during the bubble.
- Assert rst for one cycle while 3 samples are in flight → dvalid stays 0 and dout1 = dout2 = 128 from the next cycle. Full sweep of phase 0..255 after that matches the golden model exactly.
